aes_cbc_ctrl: RTL
=================

Name: aes_cbc_ctrl

Overview:
Sequences the AES-128 core in CBC mode for the SPI command path. It accepts start_encryption and new_message from spi_slave and forms the core input block: plaintext XOR IV for a new message, plaintext XOR the previous ciphertext for a continuation. It launches the core, waits for its done strobe, latches the result as the ciphertext and chaining value, and returns a held encryption_done to spi_slave.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in RUN waiting for core_done before abort
DONE_HOLD, 4, cycles encryption_done stays high (>=1)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, synchronous, active-high
start_encryption  in  1  request from spi_slave; level sampled in IDLE only
new_message  in  1  sampled with start_encryption: 1 = chain from iv, 0 = chain from last ciphertext
plaintext  in  128  block to encrypt, bit 127 = first SPI byte MSB
key  in  128  AES key
iv  in  128  initialisation vector
encryption_done  out  1  completion, high DONE_HOLD cycles
ciphertext  out  128  last completed result, registered
busy  out  1  high in every state except IDLE
chain_err  out  1  one-cycle pulse: continuation requested with no valid chain
timeout  out  1  one-cycle pulse: core_done not seen within TIMEOUT_CYCLES
core_start  out  1  one-cycle launch strobe to AES core
core_key  out  128  key presented to core, registered
core_block  out  128  XORed input block, registered
core_done  in  1  one-cycle completion strobe from AES core
core_result  in  128  core output, valid when core_done=1

Behaviour:
- Reset (rst=1 at a clk edge) drives state=IDLE, all outputs 0, chain_reg=0, chain_valid=0, counters 0. Reset applies mid-operation. A later core_done from an aborted run is ignored because core_done is sampled only in RUN.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if start_encryption=1 at edge N:
  - operand = iv when new_message=1 or chain_valid=0; otherwise operand = chain_reg.
  - chain_err pulses at N+1 when new_message=0 and chain_valid=0.
  - core_block <= plaintext ^ operand, core_key <= key. Both are held unchanged until the next accepted request.
  - Go to LOAD.
- LOAD (cycle N+1): core_start=1 for exactly this cycle. Timeout counter cleared. Go to RUN.
- RUN:
  - core_done=1 -> ciphertext <= core_result, chain_reg <= core_result, chain_valid <= 1, go to DONE. Result is visible on ciphertext the cycle DONE is entered.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: timeout pulses, chain_valid <= 0, ciphertext is unchanged, go to IDLE.
  - core_done in the same cycle the counter reaches its limit: done wins.
- DONE: encryption_done=1 for DONE_HOLD consecutive cycles, then IDLE.
- start_encryption while busy=1 is ignored (no queueing). spi_slave re-issues the request after encryption_done.
- Minimum turnaround: a request held high across DONE->IDLE is accepted on the first IDLE cycle.
- Inputs plaintext/key/iv/new_message are only sampled at acceptance. Later changes do not affect the run in flight.
- Latency: request edge N -> core_start at N+1 -> core_done at N+1+L -> encryption_done first high at N+2+L.

Test Plan:
- Reset check: rst=1 for 3 cycles while core_done toggles -> all outputs 0, busy=0, no core_start.
- New message: key=00112233445566778899AABBCCDDEEFF, iv=AABBCCDDEEFF00112233445566778899, plaintext=112233445566778899AABBCCDDEEFF00, new_message=1, start pulse. Bench core model returns CAFEBABEDEADBEEFFEEDFACE01234567 after 10 cycles. Required:
  - core_block=BB99FF99BB997799BB99FF99BB997799.
  - core_start one cycle at N+1.
  - ciphertext=CAFEBABE... and encryption_done high 4 cycles from N+12.
- Continuation: same plaintext, new_message=0 -> core_block=DBDC89FA8BCBC96767474102DCCDBA67 (chained from previous ciphertext).
- Chain error: after reset, new_message=0 request -> chain_err pulse, core_block=plaintext^iv, run completes normally.
- Timeout: core model never asserts done -> timeout pulse exactly TIMEOUT_CYCLES cycles after RUN entry, ciphertext unchanged. A following new_message=0 request raises chain_err.
- Busy/abort:
  - start pulses during RUN -> no second core_start.
  - rst asserted in RUN, then a late core_done -> ciphertext stays 0, encryption_done stays 0.

Source files
------------

// File: rtl/aes_cbc_ctrl.sv
// CBC sequencer for the AES-128 core: forms block = pt ^ (iv | last ct), launches, latches result.
// Request edge N -> core_start N+1 -> done L later -> encryption_done held DONE_HOLD; requests while busy are dropped.
module aes_cbc_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DONE_HOLD      = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_encryption,
   input  logic         new_message,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   output logic         encryption_done,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic         chain_err,
   output logic         timeout,
   output logic         core_start,
   output logic [127:0] core_key,
   output logic [127:0] core_block,
   input  logic         core_done,
   input  logic [127:0] core_result
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int HW = $clog2(DONE_HOLD + 1);
   localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] to_cnt, to_cnt_nxt, to_inc;
   logic [HW-1:0] hold_cnt, hold_cnt_nxt;
   logic [127:0]  chain_reg;
   logic          chain_valid;
   logic          accept, use_iv, to_hit, res_take;

   assign use_iv = new_message | ~chain_valid;
   assign to_inc = to_cnt + TW'(1);

   always_comb begin
      state_nxt       = state;
      to_cnt_nxt      = to_cnt;
      hold_cnt_nxt    = hold_cnt;
      busy            = 1'b1;
      core_start      = 1'b0;
      encryption_done = 1'b0;
      accept          = 1'b0;
      to_hit          = 1'b0;
      res_take        = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start_encryption) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            core_start = 1'b1;
            to_cnt_nxt = '0;
            state_nxt  = RUN;
         end
         RUN: begin
            // core_done takes priority over the timeout expiring on the same edge
            if (core_done) begin
               res_take     = 1'b1;
               hold_cnt_nxt = '0;
               state_nxt    = DONE;
            end else if (to_inc == TO_LIM) begin
               to_hit    = 1'b1;
               state_nxt = IDLE;
            end else begin
               to_cnt_nxt = to_inc;
            end
         end
         DONE: begin
            encryption_done = 1'b1;
            if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            else                       hold_cnt_nxt = hold_cnt + HW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         to_cnt      <= '0;
         hold_cnt    <= '0;
         chain_reg   <= '0;
         chain_valid <= 1'b0;
         ciphertext  <= '0;
         core_key    <= '0;
         core_block  <= '0;
         chain_err   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state     <= state_nxt;
         to_cnt    <= to_cnt_nxt;
         hold_cnt  <= hold_cnt_nxt;
         chain_err <= accept & ~new_message & ~chain_valid;
         timeout   <= to_hit;
         if (accept) begin
            core_block <= plaintext ^ (use_iv ? iv : chain_reg);
            core_key   <= key;
         end
         if (res_take) begin
            ciphertext  <= core_result;
            chain_reg   <= core_result;
            chain_valid <= 1'b1;
         end
         // an aborted run leaves no trustworthy chaining value
         if (to_hit) chain_valid <= 1'b0;
      end
   end

endmodule
